// File: rtl/decoder_nto2n_pipe_pkg.sv
// decoder_nto2n_pipe_pkg: state encoding and output-width helper shared by the decoder files
`ifndef DECODER_NTO2N_PIPE_PKG_SV
`define DECODER_NTO2N_PIPE_PKG_SV
package decoder_nto2n_pipe_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, SCAN = 2'd2} state_t;
  function automatic int out_w(input int in_w);
    return 1 << in_w;
  endfunction
endpackage
`endif

// File: rtl/decoder_nto2n_pipe_onehot.sv
// decoder_onehot: combinational binary select to one-hot code
module decoder_onehot
  import decoder_nto2n_pipe_pkg::*;
#(
  parameter int IN_W = 2,
  parameter int OUT_W = out_w(IN_W)
) (
  input  logic [IN_W-1:0]  sel,
  output logic [OUT_W-1:0] onehot
);
  assign onehot = OUT_W'(1) << sel;
endmodule

// File: rtl/decoder_nto2n_pipe.sv
// decoder_nto2n_pipe: handshaked registered N-to-2^N decoder; walking scan built only with DECODER_NTO2N_PIPE_SCAN_EN
module decoder_nto2n_pipe
  import decoder_nto2n_pipe_pkg::*;
#(
  parameter int IN_W = 2,
  parameter int DWELL_W = 8,
  localparam int OUT_W = out_w(IN_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_sel,
  input  logic               scan_mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out_onehot,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               scan_wrap
);
  state_t state, state_n;
  logic [OUT_W-1:0] code, code_n, dec;
  logic accept;
  decoder_onehot #(.IN_W(IN_W)) u_onehot (.sel(in_sel), .onehot(dec));
  assign out_valid = state != IDLE;
  assign out_onehot = code;
  assign in_ready = ~rst & en & (state != SCAN) & (~out_valid | out_ready);
  assign accept = in_valid & in_ready;
`ifdef DECODER_NTO2N_PIPE_SCAN_EN
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic wrap_q, wrap_n;
  assign scan_wrap = wrap_q & en;
  // next state: scan walks the code on dwell expiry; a pending scan request beats a new accept
  always_comb begin
    state_n = state;
    code_n = code;
    cnt_n = cnt;
    wrap_n = 1'b0;
    if (en) begin
      if (state == SCAN) begin
        if (!scan_mode) begin
          state_n = IDLE;
          code_n = '0;
        end else if (cnt == '0) begin
          cnt_n = dwell;
          code_n = {code[OUT_W-2:0], code[OUT_W-1]};
          wrap_n = code[OUT_W-1];
        end else cnt_n = cnt - DWELL_W'(1);
      end else if (scan_mode & (state == IDLE | out_ready)) begin
        state_n = SCAN;
        code_n = OUT_W'(1);
        cnt_n = dwell;
      end else if (accept) begin
        state_n = HOLD;
        code_n = dec;
      end else if (out_valid & out_ready) begin
        state_n = IDLE;
        code_n = '0;
      end
    end
  end
  // state, code, dwell counter and wrap pulse registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      code <= '0;
      cnt <= '0;
      wrap_q <= 1'b0;
    end else begin
      state <= state_n;
      code <= code_n;
      cnt <= cnt_n;
      wrap_q <= wrap_n;
    end
`else
  logic unused_scan;
  assign unused_scan = ^{scan_mode, dwell};
  assign scan_wrap = 1'b0;
  // next state: load on accept, drop to idle once the held code is consumed
  always_comb begin
    state_n = state;
    code_n = code;
    if (en & accept) begin
      state_n = HOLD;
      code_n = dec;
    end else if (en & out_valid & out_ready) begin
      state_n = IDLE;
      code_n = '0;
    end
  end
  // state and code registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      code <= '0;
    end else begin
      state <= state_n;
      code <= code_n;
    end
`endif
endmodule

// File: tb/tb_decoder_nto2n_pipe.sv
// tb_decoder_nto2n_pipe: vector table, hand sequences and randomized run against a position-based model
module tb_decoder_nto2n_pipe;
`ifdef DECODER_NTO2N_PIPE_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif
  typedef struct {
    logic v;
    logic [1:0] sel;
    logic r;
    logic [3:0] exp_oh;
    logic exp_ov;
  } vec_t;
  logic clk = 0, rst = 1, en = 1, in_valid = 0, out_ready = 0, scan_mode = 0;
  logic [1:0] in_sel = 0;
  logic [7:0] dwell = 0;
  logic in_ready, out_valid, scan_wrap;
  logic [3:0] out_onehot;
  logic v3 = 0, s3 = 0, r3, ov3, w3;
  logic [2:0] sel3 = 0;
  logic [7:0] o3;
  int tests = 0, fails = 0;
  int m_mode = 0, m_pos = 0, m_cnt = 0;
  bit m_wrap = 0;
  vec_t vecs[8];
  always #5 clk = ~clk;
  decoder_nto2n_pipe dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .scan_mode(scan_mode), .dwell(dwell), .out_onehot(out_onehot), .out_valid(out_valid),
    .out_ready(out_ready), .scan_wrap(scan_wrap)
  );
  decoder_nto2n_pipe #(.IN_W(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(v3), .in_ready(r3), .in_sel(sel3),
    .scan_mode(s3), .dwell(dwell), .out_onehot(o3), .out_valid(ov3),
    .out_ready(1'b1), .scan_wrap(w3)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    bit rdy;
    #1;
    rdy = en && m_mode != 2 && (m_mode == 0 || out_ready);
    chk("in_ready", in_ready, rdy);
    m_wrap = 0;
    if (en) begin
      if (m_mode == 2) begin
        if (!scan_mode) m_mode = 0;
        else if (m_cnt == 0) begin
          m_cnt = dwell;
          m_wrap = m_pos == 3;
          m_pos = (m_pos + 1) % 4;
        end else m_cnt--;
      end else if (SCAN_ON && scan_mode && (m_mode == 0 || out_ready)) begin
        m_mode = 2;
        m_pos = 0;
        m_cnt = dwell;
      end else if (in_valid && rdy) begin
        m_mode = 1;
        m_pos = in_sel;
      end else if (m_mode == 1 && out_ready) m_mode = 0;
    end
    @(posedge clk);
    #1;
    chk("out_onehot", out_onehot, m_mode == 0 ? 64'd0 : 64'd1 << m_pos);
    chk("out_valid", out_valid, m_mode != 0);
    chk("scan_wrap", scan_wrap, m_wrap);
  endtask
  initial begin
    vecs[0] = '{1, 2, 1, 4'b0100, 1};
    vecs[1] = '{1, 0, 1, 4'b0001, 1};
    vecs[2] = '{0, 0, 0, 4'b0001, 1};
    vecs[3] = '{1, 3, 0, 4'b0001, 1};
    vecs[4] = '{0, 0, 1, 4'b0000, 0};
    vecs[5] = '{1, 3, 0, 4'b1000, 1};
    vecs[6] = '{1, 1, 1, 4'b0010, 1};
    vecs[7] = '{0, 0, 1, 4'b0000, 0};
    #3;
    chk("rst_onehot", out_onehot, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wrap", scan_wrap, 0);
    rst = 0;
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      in_valid = vecs[i].v;
      in_sel = vecs[i].sel;
      out_ready = vecs[i].r;
      tick();
      chk("vec_onehot", out_onehot, vecs[i].exp_oh);
      chk("vec_valid", out_valid, vecs[i].exp_ov);
    end
    in_valid = 1;
    in_sel = 3;
    out_ready = 0;
    tick();
    chk("bp_load", out_onehot, 4'b1000);
    in_sel = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", out_onehot, 4'b1000);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    in_valid = 1;
    in_sel = 1;
    out_ready = 0;
    tick();
    chk("hold_sel1", out_onehot, 4'b0010);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("async_onehot", out_onehot, 0);
    chk("async_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 0);
    m_mode = 0;
    #1 rst = 0;
    @(posedge clk);
    #1;
    scan_mode = 1;
    dwell = 2;
    if (SCAN_ON) begin
      for (int k = 0; k < 14; k++) begin
        tick();
        chk("scan_pos", out_onehot, 4'd1 << ((k / 3) % 4));
        chk("scan_wrap_pulse", scan_wrap, k == 12);
      end
      en = 0;
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("freeze_pos", out_onehot, 4'b0001);
        chk("freeze_wrap", scan_wrap, 0);
      end
      en = 1;
      tick();
      chk("resume_hold", out_onehot, 4'b0001);
      tick();
      chk("resume_step", out_onehot, 4'b0010);
      scan_mode = 0;
      tick();
      chk("scan_exit_onehot", out_onehot, 0);
      chk("scan_exit_valid", out_valid, 0);
    end else begin
      tick();
      chk("noscan_idle", out_valid, 0);
    end
    scan_mode = 0;
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 7) != 0;
      in_valid = $urandom_range(0, 1);
      in_sel = 2'($urandom_range(0, 3));
      out_ready = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 19) == 0) scan_mode = ~scan_mode;
      dwell = 8'($urandom_range(0, 3));
      tick();
    end
    en = 1;
    in_valid = 0;
    out_ready = 1;
    scan_mode = 0;
    s3 = !SCAN_ON;
    @(posedge clk);
    #1;
    chk("w3_no_scan", o3, 0);
    v3 = 1;
    sel3 = 7;
    @(posedge clk);
    #1;
    chk("w3_onehot", o3, 8'h80);
    chk("w3_valid", ov3, 1);
    chk("w3_wrap", w3, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
